// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
//
// Generates the DES round subkeys for one 64-bit key, one subkey per accepted
// handshake on the sk_* stream. Encrypt mode issues rounds 1..ROUNDS in order;
// decrypt mode issues them in reverse order. The decrypt start point is
// reached with a single rotation that is computed at elaboration.
//
// Parameters
//   ROUNDS     number of subkeys per key (1..16)
//   SHIFT_MAP  bit i = 1 -> round i+1 rotates left by 1, else by 2
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   key        64-bit DES key, key[63] is DES bit 1
//   key_valid  key/decrypt valid this cycle
//   key_ready  block is idle and can take a key
//   decrypt    sampled with key, 1 = reverse subkey order
//   abort      synchronous cancel, wins over any simultaneous handshake
//   sk         48-bit round subkey, sk[47] is PC-2 output bit 1
//   sk_valid   sk / sk_round / sk_last are valid
//   sk_ready   consumer takes sk this cycle
//   sk_round   round number minus 1
//   sk_last    final subkey of the current key
//   parity_err (only with DES_KEY_PARITY_CHECK_EN) one-cycle pulse when a
//              key with an even-parity byte is offered
//
// Optional feature: define DES_KEY_PARITY_CHECK_EN to reject keys whose bytes
// are not all odd parity. Without it the parity bits are simply ignored.
// -----------------------------------------------------------------------------
module des_key_schedule #(
    parameter int          ROUNDS    = 16,
    parameter logic [15:0] SHIFT_MAP = 16'h8103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        decrypt,
    input  logic        abort,
    output logic [47:0] sk,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [3:0]  sk_round,
    output logic        sk_last
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    output logic        parity_err
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Permuted choice tables, 1-based DES bit numbers.
    localparam logic [6:0] PC1_TAB [0:55] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [5:0] PC2_TAB [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // PC-1: DES bit n lives at key[64-n]; output bit 1 lands in [55].
    function automatic logic [55:0] pc1_perm(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  src;
        r = 56'd0;
        for (int i = 0; i < 56; i++) begin
            src       = 6'(7'd64 - PC1_TAB[i]);
            r[55 - i] = k[src];
        end
        return r;
    endfunction

    // PC-2 over the concatenated {C, D}; C bit 1 is cd[55].
    function automatic logic [47:0] pc2_perm(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        logic [47:0] r;
        logic [5:0]  src;
        cd = {c, d};
        r  = 48'd0;
        for (int i = 0; i < 48; i++) begin
            src       = 6'd56 - PC2_TAB[i];
            r[47 - i] = cd[src];
        end
        return r;
    endfunction

    // Rotations of a 28-bit half; the doubled copy makes the wrap free.
    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] n);
        logic [55:0] t;
        t = {x, x} << n;
        return t[55:28];
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [4:0] n);
        logic [55:0] t;
        t = {x, x} >> n;
        return t[27:0];
    endfunction

    // Rotation amount of the round with zero-based index r.
    function automatic logic [4:0] shift_amt(input logic [3:0] r);
        logic [4:0] a;
        if (SHIFT_MAP[r]) begin
            a = 5'd1;
        end else begin
            a = 5'd2;
        end
        return a;
    endfunction

    // Total rotation of rounds 1..ROUNDS, reduced modulo the half width.
    function automatic int cum_rot();
        int s;
        s = 0;
        for (int i = 0; i < ROUNDS; i++) begin
            s = s + (SHIFT_MAP[i] ? 1 : 2);
        end
        return s % 28;
    endfunction

`ifdef DES_KEY_PARITY_CHECK_EN
    // Each key byte must carry odd parity.
    function automatic logic key_parity_ok(input logic [63:0] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            ok = ok & (^k[8*b +: 8]);
        end
        return ok;
    endfunction
`endif

    localparam logic [4:0] DEC_ROT  = 5'(cum_rot());
    localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  idx_q, idx_d;
    logic        dec_q, dec_d;
`ifdef DES_KEY_PARITY_CHECK_EN
    logic        perr_q, perr_d;
`endif

    logic [55:0] pc1_s;
    logic        key_ok_s;
    logic        run_s;
    logic        last_s;

    // Status decode shared by the next-state logic and the outputs.
    always_comb begin
        run_s = (state_q == ST_RUN);
        if (dec_q) begin
            last_s = (idx_q == 4'd0);
        end else begin
            last_s = (idx_q == LAST_IDX);
        end
        pc1_s = pc1_perm(key);
`ifdef DES_KEY_PARITY_CHECK_EN
        key_ok_s = key_parity_ok(key);
`else
        key_ok_s = 1'b1;
`endif
    end

    // Next-state logic: key load, round advance, completion and abort.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
`ifdef DES_KEY_PARITY_CHECK_EN
        perr_d  = 1'b0;
`endif
        if (abort) begin
            // Abort wins over a key accept or a subkey accept on this edge.
            state_d = ST_IDLE;
            c_d     = 28'd0;
            d_d     = 28'd0;
            idx_d   = 4'd0;
            dec_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_valid && key_ok_s) begin
                        state_d = ST_RUN;
                        dec_d   = decrypt;
                        if (decrypt) begin
                            // Jump straight to C_R/D_R, then walk backwards.
                            c_d   = rotl28(pc1_s[55:28], DEC_ROT);
                            d_d   = rotl28(pc1_s[27:0], DEC_ROT);
                            idx_d = LAST_IDX;
                        end else begin
                            c_d   = rotl28(pc1_s[55:28], shift_amt(4'd0));
                            d_d   = rotl28(pc1_s[27:0], shift_amt(4'd0));
                            idx_d = 4'd0;
                        end
                    end else if (key_valid) begin
                        // Offered key failed the parity check: stay idle.
`ifdef DES_KEY_PARITY_CHECK_EN
                        perr_d  = 1'b1;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (sk_ready && last_s) begin
                        state_d = ST_IDLE;
                        c_d     = 28'd0;
                        d_d     = 28'd0;
                        idx_d   = 4'd0;
                        dec_d   = 1'b0;
                    end else if (sk_ready && dec_q) begin
                        // Undo the current round's rotation.
                        idx_d = idx_q - 4'd1;
                        c_d   = rotr28(c_q, shift_amt(idx_q));
                        d_d   = rotr28(d_q, shift_amt(idx_q));
                    end else if (sk_ready) begin
                        // Apply the next round's rotation.
                        idx_d = idx_q + 4'd1;
                        c_d   = rotl28(c_q, shift_amt(idx_q + 4'd1));
                        d_d   = rotl28(d_q, shift_amt(idx_q + 4'd1));
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    c_d     = 28'd0;
                    d_d     = 28'd0;
                    idx_d   = 4'd0;
                    dec_d   = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= 28'd0;
            d_q     <= 28'd0;
            idx_q   <= 4'd0;
            dec_q   <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
`ifdef DES_KEY_PARITY_CHECK_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Outputs decoded from registers only; forced to zero while idle.
    always_comb begin
        key_ready = ~run_s;
        sk_valid  = run_s;
        if (run_s) begin
            sk       = pc2_perm(c_q, d_q);
            sk_round = idx_q;
            sk_last  = last_s;
        end else begin
            sk       = 48'd0;
            sk_round = 4'd0;
            sk_last  = 1'b0;
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    assign parity_err = perr_q;
`endif

endmodule
